// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback with a timed mem handshake.
module mips_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal_op,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             is_mem;
  logic             timeout;
  logic             op_mem;
  logic             op_lw;
  logic             op_r;
  logic             op_beq;
  logic             op_addi;
  logic             op_j;
  logic             op_ill;

  assign op_lw   = (opcode == 6'b100011);
  assign op_mem  = op_lw || (opcode == 6'b101011);
  assign op_r    = (opcode == 6'b000000);
  assign op_beq  = (opcode == 6'b000100);
  assign op_addi = (opcode == 6'b001000);
  assign op_j    = (opcode == 6'b000010);
  assign op_ill  = !(op_mem || op_r || op_beq
                  || op_addi || op_j);

  assign is_mem  = (state_q == S_FETCH)
                || (state_q == S_MEMRD)
                || (state_q == S_MEMWR);

  // ready in the same cycle as the limit still completes the access
  assign timeout = is_mem && !mem_ready
                && (cnt_q == TMO);

  // state, wait counter and registered error pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_FETCH;
      cnt_q      <= '0;
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      illegal_op <= (state_q == S_DECODE) && op_ill;
      mem_err    <= timeout;
    end
  end

  // next state from current state, opcode and handshake
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH:  if (mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          unique case (1'b1)
            op_mem:  state_d = S_MEMADR;
            op_r:    state_d = S_EXEC;
            op_beq:  state_d = S_BRANCH;
            op_addi: state_d = S_ADDIEX;
            op_j:    state_d = S_JUMP;
            default: state_d = S_FETCH;
          endcase
        end
        S_MEMADR: state_d = op_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWR:  if (mem_ready) state_d = S_FETCH;
        S_EXEC:   state_d = S_ALUWB;
        S_ADDIEX: state_d = S_ADDIWB;
        S_MEMWB,
        S_ALUWB,
        S_BRANCH,
        S_ADDIWB,
        S_JUMP:   state_d = S_FETCH;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // wait counter: restarts on any state change, saturates at the limit
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q || mem_ready || timeout)
      cnt_d = '0;
    else if (is_mem && cnt_q != TMO)
      cnt_d = cnt_q + 1'b1;
  end

  // datapath controls decoded from state, strobes gated by ready/zero
  always_comb begin
    mem_req  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR,
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        PCWrite = zero;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl.
// Vector table plus hand sequences for timeout and async reset.
module tb_mips_multicycle_ctrl;

  logic       CLK;
  logic       RST;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       illegal_op;
  logic       mem_err;

  mips_multicycle_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .opcode(opcode),
    .zero(zero),
    .mem_ready(mem_ready),
    .mem_req(mem_req),
    .MemWrite(MemWrite),
    .IorD(IorD),
    .IRWrite(IRWrite),
    .PCWrite(PCWrite),
    .RegWrite(RegWrite),
    .RegDst(RegDst),
    .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp),
    .PCSrc(PCSrc),
    .illegal_op(illegal_op),
    .mem_err(mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {req,wr,iord,irw,pcw,rw,rdst,m2r,srca,srcb,aluop,pcsrc,ill,merr}
  logic [16:0] outs;
  assign outs = {mem_req, MemWrite, IorD, IRWrite,
                 PCWrite, RegWrite, RegDst, MemtoReg,
                 ALUSrcA, ALUSrcB, ALUOp, PCSrc,
                 illegal_op, mem_err};

  localparam logic [16:0] F0   = 17'b1_0_0_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] F1   = 17'b1_0_0_1_1_0_0_0_0_01_00_00_0_0;
  localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [16:0] MA   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] MR   = 17'b1_0_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] MWB  = 17'b0_0_0_0_0_1_0_1_0_00_00_00_0_0;
  localparam logic [16:0] MW   = 17'b1_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [16:0] EX   = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [16:0] AWB  = 17'b0_0_0_0_0_1_1_0_0_00_00_00_0_0;
  localparam logic [16:0] BR1  = 17'b0_0_0_0_1_0_0_0_1_00_01_01_0_0;
  localparam logic [16:0] BR0  = 17'b0_0_0_0_0_0_0_0_1_00_01_01_0_0;
  localparam logic [16:0] AX   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [16:0] AXWB = 17'b0_0_0_0_0_1_0_0_0_00_00_00_0_0;
  localparam logic [16:0] JMP  = 17'b0_0_0_0_1_0_0_0_0_00_00_10_0_0;
  localparam logic [16:0] ILL  = 17'b0_0_0_0_0_0_0_0_0_00_00_00_1_0;
  localparam logic [16:0] MERR = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_1;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        r;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];
  int   n_checks;
  int   n_fail;

  function automatic void add(input logic [5:0] op,
                              input logic z,
                              input logic r,
                              input logic [16:0] e,
                              input string nm);
    vec_t v;
    v.op   = op;
    v.z    = z;
    v.r    = r;
    v.exp  = e;
    v.name = nm;
    tbl.push_back(v);
  endfunction

  task automatic check(input logic [16:0] e,
                       input string nm);
    n_checks++;
    if (outs !== e) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, outs, e);
    end
  endtask

  task automatic step(input logic [5:0] op,
                      input logic z,
                      input logic r,
                      input logic [16:0] e,
                      input string nm);
    @(negedge CLK);
    opcode    = op;
    zero      = z;
    mem_ready = r;
    #1;
    check(e, nm);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    RST       = 1'b0;
    opcode    = RT;
    zero      = 1'b0;
    mem_ready = 1'b0;

    add(LW,   0, 1, F1,   "lw_fetch");
    add(LW,   0, 1, DEC,  "lw_dec");
    add(LW,   0, 1, MA,   "lw_memadr");
    add(LW,   0, 1, MR,   "lw_memrd");
    add(LW,   0, 1, MWB,  "lw_memwb");
    add(RT,   0, 1, F1,   "r_fetch");
    add(RT,   0, 1, DEC,  "r_dec");
    add(RT,   0, 1, EX,   "r_exec");
    add(RT,   0, 1, AWB,  "r_aluwb");
    add(BEQ,  1, 1, F1,   "beq1_fetch");
    add(BEQ,  1, 1, DEC,  "beq1_dec");
    add(BEQ,  1, 1, BR1,  "beq_taken");
    add(BEQ,  0, 1, F1,   "beq0_fetch");
    add(BEQ,  0, 1, DEC,  "beq0_dec");
    add(BEQ,  0, 1, BR0,  "beq_not_taken");
    add(ADDI, 0, 1, F1,   "addi_fetch");
    add(ADDI, 0, 1, DEC,  "addi_dec");
    add(ADDI, 0, 1, AX,   "addi_ex");
    add(ADDI, 0, 1, AXWB, "addi_wb");
    add(J,    0, 1, F1,   "j_fetch");
    add(J,    0, 1, DEC,  "j_dec");
    add(J,    0, 1, JMP,  "j_jump");
    add(SW,   0, 1, F1,   "sw_fetch");
    add(SW,   0, 1, DEC,  "sw_dec");
    add(SW,   0, 1, MA,   "sw_memadr");
    add(SW,   0, 0, MW,   "sw_wait1");
    add(SW,   0, 0, MW,   "sw_wait2");
    add(SW,   0, 0, MW,   "sw_wait3");
    add(SW,   0, 1, MW,   "sw_done");
    for (int i = 0; i < 5; i++)
      add(RT, 0, 0, F0,   "tmo_wait");
    add(RT,   0, 0, F0 | MERR, "tmo_err");
    for (int i = 0; i < 3; i++)
      add(RT, 0, 0, F0,   "tmo_refetch");
    add(RT,   0, 1, F1,   "tmo_ready_wins");
    add(RT,   0, 0, DEC,  "tmo_no_err");
    add(RT,   0, 0, EX,   "tmo_exec");
    add(RT,   0, 1, AWB,  "tmo_aluwb");
    add(BAD,  0, 1, F1,   "ill_fetch");
    add(BAD,  0, 1, DEC,  "ill_dec");
    add(BAD,  0, 0, F0 | ILL, "ill_pulse");
    add(RT,   0, 0, F0,   "ill_gone");
    add(RT,   0, 1, F1,   "ill_next_fetch");
    add(RT,   0, 0, DEC,  "ill_next_dec");

    #12;
    check(F0, "reset_state");
    @(negedge CLK);
    RST = 1'b1;

    foreach (tbl[i])
      step(tbl[i].op, tbl[i].z, tbl[i].r,
           tbl[i].exp, tbl[i].name);

    step(RT, 0, 0, EX,  "pre_rst_exec");
    step(RT, 0, 0, AWB, "pre_rst_aluwb");
    step(LW, 0, 1, F1,  "rst_fetch");
    step(LW, 0, 1, DEC, "rst_dec");
    step(LW, 0, 0, MA,  "rst_memadr");
    step(LW, 0, 0, MR,  "rst_memrd");
    #2;
    RST = 1'b0;
    #1;
    check(F0, "rst_async");
    @(posedge CLK);
    #1;
    check(F0, "rst_held");
    @(negedge CLK);
    RST = 1'b1;
    step(LW, 0, 0, F0,  "rst_rel_wait");
    step(LW, 0, 1, F1,  "rst_rel_fetch");
    step(LW, 0, 1, DEC, "rst_rel_dec");

    step(LW,  0, 1, MA,  "ill2_memadr");
    step(LW,  0, 1, MR,  "ill2_memrd");
    step(LW,  0, 1, MWB, "ill2_memwb");
    step(BAD, 0, 1, F1,  "ill2_fetch");
    step(BAD, 0, 1, DEC, "ill2_dec");
    step(BAD, 0, 0, F0 | ILL, "ill2_pulse");
    RST = 1'b0;
    #1;
    check(F0, "rst_clears_ill");
    @(negedge CLK);
    RST = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
